// File: rtl/npc_ctrl_pkg.sv
// Shared types for the NPC stage sequencer: FSM state, halt reasons and
// memory-operation codes delivered by the decoder.
package npc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    HALT_NONE    = 2'd0,
    HALT_EBREAK  = 2'd1,
    HALT_ILLEGAL = 2'd2,
    HALT_TIMEOUT = 2'd3
  } halt_code_t;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_t;

  // States that wait on a unit's done handshake and are guarded by the watchdog.
  function automatic logic is_wait_state(state_t s);
    return (s == S_IF) || (s == S_ID) || (s == S_EX) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/npc_stage_ctrl_if.sv
// Start/done handshake bundle between the stage sequencer (master) and the
// IFU/IDU/EXU/LSU units (slave).
interface npc_stage_ctrl_if;

  logic       ifu_start;
  logic       ifu_done;
  logic       idu_start;
  logic       idu_done;
  logic       ebreak;
  logic       illegal;
  logic [1:0] mem_op;
  logic       exu_start;
  logic       exu_done;
  logic       lsu_req;
  logic       lsu_wen;
  logic       lsu_done;
  logic       rf_we;
  logic       pc_we;

  modport master (
    output ifu_start, idu_start, exu_start, lsu_req, lsu_wen, rf_we, pc_we,
    input  ifu_done, idu_done, ebreak, illegal, mem_op, exu_done, lsu_done
  );

  modport slave (
    input  ifu_start, idu_start, exu_start, lsu_req, lsu_wen, rf_we, pc_we,
    output ifu_done, idu_done, ebreak, illegal, mem_op, exu_done, lsu_done
  );

endinterface

// File: rtl/npc_stage_watchdog.sv
// Per-stage cycle counter: cleared on stage entry, counts waiting cycles and
// flags expiry once TIMEOUT-1 waiting cycles have elapsed.
module npc_stage_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  assign expire = (cnt == CNT_LAST);

  // Holds at the last value so expiry stays visible until the stage is left.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/npc_stage_ctrl.sv
// Multi-cycle sequencer for the single-issue NPC core: steps one instruction
// through IF/ID/EX/(MEM)/WB and owns rf/pc strobes, retire count and halting.
module npc_stage_ctrl
  import npc_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  npc_stage_ctrl_if.master  bus,
  output logic              halted,
  output logic [1:0]        halt_code,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [2:0]        state
);

  state_t           st;
  logic             entry;
  mem_op_t          mem_q;
  halt_code_t       halt_q;
  logic             halted_q;
  logic [CNT_W-1:0] retire_q;

  logic stage_done;
  logic waiting;
  logic wd_expire;
  logic timeout;
  logic advance;
  logic dec_illegal;

  assign waiting = is_wait_state(st);

  always_comb begin
    stage_done = 1'b0;
    case (st)
      S_IF:    stage_done = bus.ifu_done;
      S_ID:    stage_done = bus.idu_done;
      S_EX:    stage_done = bus.exu_done;
      S_MEM:   stage_done = bus.lsu_done;
      default: stage_done = 1'b0;
    endcase
  end

  // A done arriving in the expiry cycle wins over the timeout.
  assign timeout     = waiting && !stage_done && wd_expire;
  assign advance     = (waiting && stage_done) || timeout || (st == S_WB);
  assign dec_illegal = bus.illegal || (mem_op_t'(bus.mem_op) == MEM_RSVD);

  npc_stage_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (advance),
    .en     (waiting && !stage_done),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= S_IF;
      entry    <= 1'b1;
      mem_q    <= MEM_NONE;
      halt_q   <= HALT_NONE;
      halted_q <= 1'b0;
      retire_q <= '0;
    end else begin
      entry <= advance;
      if (timeout) begin
        st       <= S_HALT;
        halt_q   <= HALT_TIMEOUT;
        halted_q <= 1'b1;
      end else begin
        case (st)
          S_IF: begin
            if (bus.ifu_done) st <= S_ID;
          end
          S_ID: begin
            if (bus.idu_done) begin
              if (dec_illegal) begin
                st       <= S_HALT;
                halt_q   <= HALT_ILLEGAL;
                halted_q <= 1'b1;
              end else if (bus.ebreak) begin
                // ebreak counts as retired but never writes rf or pc.
                st       <= S_HALT;
                halt_q   <= HALT_EBREAK;
                halted_q <= 1'b1;
                retire_q <= retire_q + CNT_W'(1);
              end else begin
                mem_q <= mem_op_t'(bus.mem_op);
                st    <= S_EX;
              end
            end
          end
          S_EX: begin
            if (bus.exu_done) st <= (mem_q != MEM_NONE) ? S_MEM : S_WB;
          end
          S_MEM: begin
            if (bus.lsu_done) st <= S_WB;
          end
          S_WB: begin
            retire_q <= retire_q + CNT_W'(1);
            st       <= S_IF;
          end
          S_HALT: begin
            st <= S_HALT;
          end
          default: begin
            st <= S_IF;
          end
        endcase
      end
    end
  end

  // Strobes are decoded from registered state; rst masks them in its own cycle.
  assign bus.ifu_start = !rst && entry && (st == S_IF);
  assign bus.idu_start = !rst && entry && (st == S_ID);
  assign bus.exu_start = !rst && entry && (st == S_EX);
  assign bus.lsu_req   = !rst && (st == S_MEM);
  assign bus.lsu_wen   = bus.lsu_req && (mem_q == MEM_STORE);
  assign bus.pc_we     = !rst && (st == S_WB);
  assign bus.rf_we     = bus.pc_we && (mem_q != MEM_STORE);

  assign halted     = halted_q;
  assign halt_code  = halt_q;
  assign retire_cnt = retire_q;
  assign state      = st;

endmodule

// File: doc/npc_stage_ctrl.md
Name: npc_stage_ctrl

Overview:
- Central multi-cycle sequencer for the single-issue NPC core.
- Runs one instruction at a time through IF -> ID -> EX -> (MEM) -> WB using start/done handshakes with IFU, IDU, EXU and LSU.
- Replaces the ad-hoc per-unit done chaining.
- Owns the register-file write enable, the PC update strobe, the retire counter and the halt/trap decision (ebreak, illegal instruction, stage timeout).

Parameters:
- CNT_W, 32: width of retire_cnt.
- TIMEOUT, 1024: maximum cycles any stage may take to return done before a trap; must be >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ifu_start  out  1  one-cycle pulse: fetch at current PC.
- ifu_done  in  1  instruction word valid at IDU input.
- idu_start  out  1  one-cycle pulse: decode latched instruction.
- idu_done  in  1  decode fields stable.
- ebreak  in  1  decoded instruction is ebreak; sampled with idu_done.
- illegal  in  1  decoded instruction is invalid (e.g. bad shamt); sampled with idu_done.
- mem_op  in  2  from IDU, sampled with idu_done: 00 none, 01 load, 10 store, 11 reserved (treated as illegal).
- exu_start  out  1  one-cycle pulse: execute.
- exu_done  in  1  ALU result / branch target valid.
- lsu_req  out  1  held high while in MEM until lsu_done.
- lsu_wen  out  1  1 for store, valid while lsu_req is high.
- lsu_done  in  1  memory access complete.
- rf_we  out  1  register-file write strobe, one cycle.
- pc_we  out  1  PC update strobe, one cycle.
- halted  out  1  core stopped, sticky until rst.
- halt_code  out  2  0 none, 1 ebreak, 2 illegal, 3 timeout.
- retire_cnt  out  CNT_W  number of retired instructions.
- state  out  3  current FSM state, for debug/difftest.

Behaviour:
- States: S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT.
- Reset, in the cycle rst is high:
  - state <= S_IF; retire_cnt, halt_code, halted <= 0.
  - All strobes and lsu_req are 0 during rst.
  - The latched mem_op register is cleared.
- Entry flag: a registered flag is set on every state transition and in the first cycle after rst deasserts.
  - *_start is asserted only in the cycle the entry flag is set, giving exactly one pulse per state visit.
  - ifu_start is therefore high in the first cycle after reset release.
- Done inputs are accepted in any cycle of the matching state, including the start cycle. Done inputs seen in any other state are ignored.
- S_IF: on ifu_done -> S_ID.
- S_ID: on idu_done, priority order:
  - illegal, or mem_op == 11 -> S_HALT with code 2; no retire.
  - ebreak -> S_HALT with code 1; retire_cnt += 1; no rf_we, no pc_we.
  - otherwise latch mem_op -> S_EX.
- S_EX: on exu_done:
  - latched mem_op != 00 -> S_MEM.
  - otherwise -> S_WB.
- S_MEM:
  - lsu_req = 1 and lsu_wen = (mem_op == 10) from the first cycle of the state.
  - On lsu_done, lsu_req drops the next cycle -> S_WB.
- S_WB: single cycle.
  - pc_we = 1.
  - rf_we = 1 unless the latched op is a store.
  - retire_cnt += 1 (wraps modulo 2^CNT_W).
  - -> S_IF.
- Watchdog:
  - Counter cleared on every state entry; increments each cycle in S_IF/S_ID/S_EX/S_MEM while done is absent.
  - When it reaches TIMEOUT-1 with done still low -> S_HALT with code 3.
  - If done arrives in the same cycle as expiry, done wins.
- S_HALT: terminal; halted = 1; all strobes and lsu_req = 0; halt_code held. Only rst leaves it.
- Reset mid-operation (e.g. during S_MEM): lsu_req drops in the rst cycle; no rf_we/pc_we is issued; the sequence restarts at S_IF.
- Per-instruction latency with single-cycle units (done in the start cycle):
  - ALU op: 4 cycles, IF/ID/EX/WB.
  - Load/store: 5 cycles.

Decomposition:
- Package npc_ctrl_pkg:
  - state encoding: S_IF = 0, S_ID = 1, S_EX = 2, S_MEM = 3, S_WB = 4, S_HALT = 5.
  - halt codes and mem_op codes (MEM_NONE/LOAD/STORE).
- One sub-module, npc_stage_watchdog: counter with clear/enable inputs and an expire output, parameterised by TIMEOUT.

Test Plan:
- ALU instruction, all dones returned in the start cycle:
  - ifu_start at cycle 1, idu_start at 2, exu_start at 3.
  - rf_we = pc_we = 1 at cycle 4; retire_cnt = 1; ifu_start again at cycle 5.
- Load, mem_op = 01, lsu_done 3 cycles after lsu_req rises:
  - lsu_req high for 4 cycles with lsu_wen = 0.
  - Then one WB cycle with rf_we = 1; retire_cnt increments by 1.
- Store, mem_op = 10:
  - lsu_wen = 1 while lsu_req is high.
  - WB cycle has pc_we = 1 and rf_we = 0.
- ebreak with idu_done after 2 ALU retirements:
  - halted = 1, halt_code = 1, retire_cnt = 3.
  - No further pulses for 50 cycles; illegal = 1 with ebreak = 1 gives halt_code = 2.
- Timeout, TIMEOUT = 8, exu_done never asserted:
  - S_HALT with halt_code = 3 exactly 8 cycles after exu_start.
  - With exu_done in the 8th cycle, the core proceeds to S_WB instead.
- rst asserted for one cycle in the 2nd cycle of S_MEM:
  - lsu_req = 0 in that cycle; state = S_IF; retire_cnt = 0.
  - ifu_start in the following cycle; no rf_we.
